// File: rtl/branch_resolve.sv
// Branch resolution unit: carries fetch-time predictions through an IF->ID->EX metadata pipe,
// resolves them at EX, and drives flush/redirect, predictor update and saturating statistics.
module branch_resolve #(
  parameter int unsigned PC_W         = 32,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             if_valid_i,
  input  logic [PC_W-1:0]  if_pc_i,
  input  logic             if_pred_taken_i,
  input  logic [PC_W-1:0]  if_pred_target_i,
  input  logic             ex_is_br_i,
  input  logic             ex_taken_i,
  input  logic [PC_W-1:0]  ex_target_i,
  output logic             flush_o,
  output logic             redirect_valid_o,
  output logic [PC_W-1:0]  redirect_pc_o,
  output logic             upd_is_br_o,
  output logic             upd_taken_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] mis_cnt_o
);

  localparam int unsigned FcW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e           r_state, w_state_d;
  logic [FcW-1:0]   r_fcnt, w_fcnt_d;

  logic             r_id_v, r_id_pt, r_ex_v, r_ex_pt;
  logic [PC_W-1:0]  r_id_pc, r_id_tgt, r_ex_pc, r_ex_tgt;

  logic             r_redir_v;
  logic [PC_W-1:0]  r_redir_pc;
  logic             r_upd_is_br, r_upd_taken;
  logic [CNT_W-1:0] r_br_cnt, r_mis_cnt;

  logic             w_res, w_pt, w_mis, w_flush;
  logic [PC_W-1:0]  w_rpc;

  // A missing captured prediction is treated as predicted not-taken.
  assign w_res   = ex_is_br_i & ~stall_i & (r_state == StIdle);
  assign w_pt    = r_ex_v & r_ex_pt;
  assign w_mis   = w_res & ((w_pt & ~ex_taken_i) | (~w_pt & ex_taken_i) |
                            (w_pt & ex_taken_i & (r_ex_tgt != ex_target_i)));
  assign w_rpc   = (w_pt & ~ex_taken_i) ? (r_ex_pc + PC_W'(4)) : ex_target_i;
  assign w_flush = (r_state == StFlush) | w_mis;

  always_comb begin
    w_state_d = r_state;
    w_fcnt_d  = r_fcnt;
    unique case (r_state)
      StIdle: begin
        if (w_mis) begin
          w_state_d = StFlush;
          w_fcnt_d  = FcW'(FLUSH_CYCLES - 1);
        end
      end
      StFlush: begin
        if (r_fcnt == '0) w_state_d = StIdle;
        else              w_fcnt_d  = r_fcnt - 1'b1;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_d;
      r_fcnt  <= w_fcnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_v   <= 1'b0;
      r_id_pt  <= 1'b0;
      r_id_pc  <= '0;
      r_id_tgt <= '0;
      r_ex_v   <= 1'b0;
      r_ex_pt  <= 1'b0;
      r_ex_pc  <= '0;
      r_ex_tgt <= '0;
    end else if (w_flush) begin
      r_id_v <= 1'b0;
      r_ex_v <= 1'b0;
    end else if (!stall_i) begin
      r_id_v   <= if_valid_i;
      r_id_pt  <= if_pred_taken_i;
      r_id_pc  <= if_pc_i;
      r_id_tgt <= if_pred_target_i;
      r_ex_v   <= r_id_v;
      r_ex_pt  <= r_id_pt;
      r_ex_pc  <= r_id_pc;
      r_ex_tgt <= r_id_tgt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_redir_v   <= 1'b0;
      r_redir_pc  <= '0;
      r_upd_is_br <= 1'b0;
      r_upd_taken <= 1'b0;
      r_br_cnt    <= '0;
      r_mis_cnt   <= '0;
    end else begin
      r_redir_v   <= w_mis;
      if (w_mis) r_redir_pc <= w_rpc;
      r_upd_is_br <= w_res;
      r_upd_taken <= w_res & ex_taken_i;
      if (w_res && (r_br_cnt != '1))  r_br_cnt  <= r_br_cnt + 1'b1;
      if (w_mis && (r_mis_cnt != '1)) r_mis_cnt <= r_mis_cnt + 1'b1;
    end
  end

  assign flush_o          = (r_state == StFlush);
  assign redirect_valid_o = r_redir_v;
  assign redirect_pc_o    = r_redir_pc;
  assign upd_is_br_o      = r_upd_is_br;
  assign upd_taken_o      = r_upd_taken;
  assign br_cnt_o         = r_br_cnt;
  assign mis_cnt_o        = r_mis_cnt;

`ifndef SYNTHESIS
  // Every resolution must find a captured prediction in EX.
  a_res_has_meta : assert property (@(posedge clk) disable iff (rst) w_res |-> r_ex_v)
    else $error("branch_resolve: resolution with empty EX metadata");
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: expected resolution results are queued at stimulus time
// and compared one cycle later when the update/redirect outputs appear.
module tb_branch_resolve;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall_i, if_valid_i, if_pred_taken_i, ex_is_br_i, ex_taken_i;
  logic [PC_W-1:0]  if_pc_i, if_pred_target_i, ex_target_i;
  logic             flush_o, redirect_valid_o, upd_is_br_o, upd_taken_o;
  logic [PC_W-1:0]  redirect_pc_o;
  logic [CNT_W-1:0] br_cnt_o, mis_cnt_o;

  branch_resolve #(.PC_W(PC_W), .CNT_W(CNT_W), .FLUSH_CYCLES(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall_i),
    .if_valid_i       (if_valid_i),
    .if_pc_i          (if_pc_i),
    .if_pred_taken_i  (if_pred_taken_i),
    .if_pred_target_i (if_pred_target_i),
    .ex_is_br_i       (ex_is_br_i),
    .ex_taken_i       (ex_taken_i),
    .ex_target_i      (ex_target_i),
    .flush_o          (flush_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .upd_is_br_o      (upd_is_br_o),
    .upd_taken_o      (upd_taken_o),
    .br_cnt_o         (br_cnt_o),
    .mis_cnt_o        (mis_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        mis;
    logic        taken;
    logic [31:0] rpc;
    int          br;
    int          misc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          m_br  = 0;
  int          m_mis = 0;
  logic [31:0] m_rpc = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    stall_i = 0; if_valid_i = 0; if_pc_i = '0; if_pred_taken_i = 0; if_pred_target_i = '0;
    ex_is_br_i = 0; ex_taken_i = 0; ex_target_i = '0;
  endtask

  // Capture a prediction, wait for it to reach EX, resolve it, then check the aftermath.
  task automatic resolve(input string tag, input logic [31:0] pc, input logic pt,
                         input logic [31:0] tgt, input logic taken, input logic [31:0] target,
                         input bit b2b);
    exp_t e;
    logic [31:0] p4;
    if_valid_i = 1; if_pc_i = pc; if_pred_taken_i = pt; if_pred_target_i = tgt;
    tick();
    if_valid_i = 0; if_pc_i = '0; if_pred_taken_i = 0;
    tick();
    ex_is_br_i = 1; ex_taken_i = taken; ex_target_i = target;
    p4 = pc + 32'd4;
    e.tag   = tag;
    e.taken = taken;
    e.mis   = (pt && !taken) || (!pt && taken) || (pt && taken && (tgt != target));
    e.rpc   = (pt && !taken) ? p4 : target;
    m_br    = (m_br < 15) ? m_br + 1 : 15;
    if (e.mis) begin
      m_mis = (m_mis < 15) ? m_mis + 1 : 15;
      m_rpc = e.rpc;
    end
    e.br = m_br; e.misc = m_mis;
    sb.push_back(e);
    tick();
    ex_is_br_i = b2b; ex_taken_i = 1; ex_target_i = 32'h0000_0BAD;
    e = sb.pop_front();
    chk({e.tag, ".upd_is_br"}, {31'd0, upd_is_br_o}, 32'd1);
    chk({e.tag, ".upd_taken"}, {31'd0, upd_taken_o}, {31'd0, e.taken});
    chk({e.tag, ".redir_v"}, {31'd0, redirect_valid_o}, {31'd0, e.mis});
    chk({e.tag, ".flush1"}, {31'd0, flush_o}, {31'd0, e.mis});
    chk({e.tag, ".redir_pc"}, redirect_pc_o, m_rpc);
    chk({e.tag, ".br_cnt"}, {28'd0, br_cnt_o}, e.br);
    chk({e.tag, ".mis_cnt"}, {28'd0, mis_cnt_o}, e.misc);
    tick();
    ex_is_br_i = 0; ex_taken_i = 0; ex_target_i = '0;
    if (e.mis) begin
      chk({e.tag, ".flush2"}, {31'd0, flush_o}, 32'd1);
      chk({e.tag, ".redir_pulse"}, {31'd0, redirect_valid_o}, 32'd0);
      chk({e.tag, ".br_hold"}, {28'd0, br_cnt_o}, e.br);
      tick();
    end
    chk({e.tag, ".flush_end"}, {31'd0, flush_o}, 32'd0);
  endtask

  initial begin
    quiet();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.flush", {31'd0, flush_o}, 32'd0);
    chk("rst.redir_v", {31'd0, redirect_valid_o}, 32'd0);
    chk("rst.redir_pc", redirect_pc_o, 32'd0);
    chk("rst.upd", {30'd0, upd_is_br_o, upd_taken_o}, 32'd0);
    chk("rst.cnt", {24'd0, br_cnt_o, mis_cnt_o}, 32'd0);
    rst = 0;
    tick();

    resolve("ok_taken", 32'h100, 1, 32'h200, 1, 32'h200, 0);
    resolve("pt_nt", 32'h100, 1, 32'h200, 0, 32'h0, 0);
    resolve("pnt_t", 32'h180, 0, 32'h0, 1, 32'h340, 1);
    resolve("tgt_mm", 32'h1C0, 1, 32'h200, 1, 32'h280, 0);
    resolve("wrap", 32'hFFFF_FFFC, 1, 32'h10, 0, 32'h0, 0);
    resolve("ok_nt", 32'h220, 0, 32'h0, 0, 32'h0, 0);

    // Stall holds the EX prediction while other fetches are offered.
    if_valid_i = 1; if_pc_i = 32'h500; if_pred_taken_i = 1; if_pred_target_i = 32'h600;
    tick();
    if_valid_i = 0;
    tick();
    stall_i = 1; ex_is_br_i = 1; ex_taken_i = 0;
    if_valid_i = 1; if_pc_i = 32'h900; if_pred_taken_i = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.upd", {31'd0, upd_is_br_o}, 32'd0);
      chk("stall.br", {28'd0, br_cnt_o}, m_br);
    end
    stall_i = 0; if_valid_i = 0;
    m_br = (m_br < 15) ? m_br + 1 : 15;
    m_mis = (m_mis < 15) ? m_mis + 1 : 15;
    m_rpc = 32'h504;
    tick();
    ex_is_br_i = 0;
    chk("stall.rel_redir_v", {31'd0, redirect_valid_o}, 32'd1);
    chk("stall.rel_pc", redirect_pc_o, 32'h504);
    chk("stall.rel_br", {28'd0, br_cnt_o}, m_br);
    repeat (2) tick();
    chk("stall.flush_end", {31'd0, flush_o}, 32'd0);

    for (int i = 0; i < 20; i++) resolve("sat", 32'h1000 + 32'(i * 16), 0, 32'h0, 1, 32'h2000, 0);
    chk("sat.mis", {28'd0, mis_cnt_o}, 32'd15);
    chk("sat.br", {28'd0, br_cnt_o}, 32'd15);

    // Reset in the middle of a flush.
    if_valid_i = 1; if_pc_i = 32'h700; if_pred_taken_i = 1; if_pred_target_i = 32'h800;
    tick();
    if_valid_i = 0;
    tick();
    ex_is_br_i = 1; ex_taken_i = 0;
    tick();
    ex_is_br_i = 0;
    chk("mid.flush_on", {31'd0, flush_o}, 32'd1);
    #2 rst = 1;
    #1;
    chk("mid.flush", {31'd0, flush_o}, 32'd0);
    chk("mid.redir_v", {31'd0, redirect_valid_o}, 32'd0);
    chk("mid.redir_pc", redirect_pc_o, 32'd0);
    chk("mid.cnt", {24'd0, br_cnt_o, mis_cnt_o}, 32'd0);
    m_br = 0; m_mis = 0; m_rpc = '0;
    #1 rst = 0;
    tick();
    chk("post_rst.flush", {31'd0, flush_o}, 32'd0);
    chk("post_rst.redir_v", {31'd0, redirect_valid_o}, 32'd0);
    resolve("post_rst", 32'h300, 1, 32'h400, 1, 32'h400, 0);
    chk("sb.empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_resolve.md
# branch_resolve

Branch resolution unit at the execute end of the conditional-branch prediction loop. Captures each fetch-stage prediction (direction and target) and carries it alongside the instruction through a two-register IF→ID→EX metadata pipe. At EX it compares the carried prediction with the actual outcome, then raises flush and redirect on a mispredict. One cycle after each resolved conditional branch it drives the update pair (branch-resolved, taken) that trains the 2-bit direction predictor, and it keeps saturating branch and mispredict counters.

## Interface
- PC_W, 32, width of PC and target fields
- CNT_W, 16, width of statistics counters
- FLUSH_CYCLES, 2, cycles flush_o stays high per mispredict (≥1)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall_i  in  1  freeze metadata pipe; EX resolution ignored this cycle
- if_valid_i  in  1  fetch slot holds a conditional branch
- if_pc_i  in  PC_W  PC of fetched branch
- if_pred_taken_i  in  1  predictor direction for this fetch
- if_pred_target_i  in  PC_W  predicted target (don't-care if not taken)
- ex_is_br_i  in  1  conditional branch resolving in EX
- ex_taken_i  in  1  actual outcome
- ex_target_i  in  PC_W  actual taken target
- flush_o  out  1  kill IF/ID contents
- redirect_valid_o  out  1  one-cycle pulse: load redirect_pc_o into PC
- redirect_pc_o  out  PC_W  corrected fetch address
- upd_is_br_o  out  1  previous op was resolved conditional branch
- upd_taken_o  out  1  its actual outcome
- br_cnt_o  out  CNT_W  resolved branches, saturating
- mis_cnt_o  out  CNT_W  mispredicts, saturating

## Operation
- Meta pipe: stage ID {v, pc, pt, tgt}, stage EX same. Per cycle, priority high→low:
  - flush (state FLUSH or mispredict this cycle): both v cleared.
  - stall_i: hold.
  - else: ID←IF inputs, EX←ID.
- Resolution fires when `res = ex_is_br_i & ~stall_i & state==IDLE`.
  - If res and EX.v=0 (no captured prediction), treat the prediction as not-taken at pc = ex PC unknown. Avoid this case: res must coincide with EX.v=1; an assertion checks this. Compare with the EX stage only.
- Mispredict when res and any of:
  - pt=1, taken=0 → redirect pc+4 (PC_W modulo add, wraps).
  - pt=0, taken=1 → redirect ex_target_i.
  - pt=1, taken=1, tgt≠ex_target_i → redirect ex_target_i.
- FSM:
  - IDLE: on mispredict, load counter=FLUSH_CYCLES-1 and go to FLUSH.
  - FLUSH: decrement counter, return to IDLE when counter=0 at end of cycle. ex_is_br_i is ignored (bubbles).
- Counters: br_cnt +1 on every res; mis_cnt +1 on mispredict. Both hold at 2^CNT_W-1.
- Update regs: upd_is_br_o←res, upd_taken_o←ex_taken_i when res, else 0. These are trained on every resolution, correct or not.

## Timing
- Reset values: all outputs 0, redirect_pc_o 0, FSM IDLE, pipe v bits 0, counters 0.
- Capture latency: IF inputs reach EX comparison 2 unstalled cycles later.
- Resolve cycle N (mispredict):
  - N+1: redirect_valid_o=1 for exactly one cycle, with redirect_pc_o valid that cycle (held afterwards).
  - flush_o=1 for cycles N+1 … N+FLUSH_CYCLES.
- Meta pipe is cleared at edge N and on every FLUSH edge. IF captures during flush are discarded.
- Update pair is registered: valid at N+1 for any res at N. It aligns with the predictor sampling its update inputs as "previous op".
- stall_i during FLUSH has no effect on the flush countdown.
- rst mid-flush: immediate return to IDLE, all outputs 0, no redirect.
- Simultaneous res and stall: stall wins; the branch must be re-presented.

## Test plan
- Correct taken predict: IF pc=0x100, pt=1, tgt=0x200. Two cycles later, ex_is_br=1, taken=1, target=0x200 → no flush; next cycle upd_is_br=1, upd_taken=1; br_cnt=1, mis_cnt=0.
- Predicted taken, not taken: pc=0x100, pt=1 → next cycle redirect_valid=1, redirect_pc=0x104; flush_o high 2 cycles; upd_taken=0; mis_cnt=1.
- Predicted not-taken, taken, target 0x340 → redirect_pc=0x340; a back-to-back ex_is_br on the next cycle is ignored (br_cnt unchanged).
- Target mismatch: pt=1, tgt=0x200, actual 0x280 → redirect 0x280. Wrap case: pc=0xFFFFFFFC, pt=1, not taken → redirect 0x00000000.
- Stall: stall_i=1 for 3 cycles with ex_is_br=1 → no update, meta pipe contents unchanged. On release, resolution proceeds normally.
- Saturation/reset: CNT_W=4 with 20 mispredicts → mis_cnt=15. Assert rst during FLUSH → flush_o, redirect_valid_o go 0 asynchronously and counters read 0.
